// File: rtl/lal_count_ctrl.sv
// lal_count_ctrl: run sequencer around a CNT_W-bit up-counter and KEY_W-bit key compare.
// Ports: clk/rst_n; start, cfg_limit, cfg_key, probe, hold, clr in; busy, count, done, match, aborted out.
module lal_count_ctrl #(
    parameter int CNT_W = 9,
    parameter int KEY_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic [KEY_W-1:0] probe,
    input  logic             hold,
    input  logic             clr,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             match,
    output logic             aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_COUNT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             match_q, match_d;
    logic             aborted_q, aborted_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            key_q     <= '0;
            match_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            key_q     <= key_d;
            match_q   <= match_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        key_d     = key_q;
        match_d   = match_q;
        aborted_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (clr) begin
                    count_d = '0;
                end else if (start) begin
                    limit_d = cfg_limit;
                    key_d   = cfg_key;
                    match_d = 1'b0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (clr) begin
                    count_d   = '0;
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    count_d = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                // Terminal test precedes the increment, so count never passes limit.
                if (clr) begin
                    count_d   = '0;
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (count_q == limit_q) begin
                    state_d = S_CHECK;
                end else if (!hold) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (clr) begin
                    count_d   = '0;
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    match_d = (probe == key_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // clr is deliberately ignored here; the done pulse always completes.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign count   = count_q;
    assign match   = match_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_lal_count_ctrl.sv
// tb_lal_count_ctrl: vector table, directed runs and random stimulus for lal_count_ctrl.
// Expected values come from a progress-index reference model and hand-computed tables.
module tb_lal_count_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       clr = 1'b0;
    logic [8:0] cfg_limit = '0;
    logic [3:0] cfg_key = '0;
    logic [3:0] probe = '0;
    logic       busy, done, match, aborted;
    logic [8:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lal_count_ctrl #(.CNT_W(9), .KEY_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_limit(cfg_limit),
        .cfg_key(cfg_key), .probe(probe), .hold(hold), .clr(clr),
        .busy(busy), .count(count), .done(done), .match(match),
        .aborted(aborted)
    );

    // Reference model: a run is a progress index p.
    // p=0 arm, p=1..lim+1 counting, p=lim+2 compare, p=lim+3 done.
    bit       m_run;
    int       m_p, m_lim, m_count;
    bit [3:0] m_key;
    bit       m_match, m_ab;

    function automatic bit m_done();
        return m_run && (m_p == m_lim + 3);
    endfunction

    task automatic model_reset();
        m_run = 0; m_p = 0; m_lim = 0; m_count = 0;
        m_key = 0; m_match = 0; m_ab = 0;
    endtask

    task automatic model_step();
        bit ab_n;
        ab_n = 0;
        if (!m_run) begin
            if (clr) m_count = 0;
            else if (start) begin
                m_run = 1; m_p = 0; m_lim = int'(cfg_limit);
                m_key = cfg_key; m_match = 0;
            end
        end else if (m_p == m_lim + 3) begin
            m_run = 0;
        end else if (clr) begin
            m_run = 0; m_count = 0; ab_n = 1;
        end else if (m_p == 0) begin
            m_count = 0; m_p = 1;
        end else if (m_p <= m_lim + 1) begin
            if (m_count == m_lim) m_p++;
            else if (!hold) begin m_count++; m_p++; end
        end else begin
            m_match = (probe == m_key); m_p++;
        end
        m_ab = ab_n;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("busy", 32'(busy), 32'(m_run));
        chk("count", 32'(count), 32'(m_count));
        chk("done", 32'(done), 32'(m_done()));
        chk("match", 32'(match), 32'(m_match));
        chk("aborted", 32'(aborted), 32'(m_ab));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Start a run and count edges until done; optional hold window and busy restarts.
    task automatic run(input int lim, input logic [3:0] key, input logic [3:0] prb,
                       input int hold_at, input int hold_n, input bit restart,
                       input int exp_edge, input bit exp_match, input string name);
        int edge_n;
        start = 1; cfg_limit = 9'(lim); cfg_key = key; probe = prb; hold = 0; clr = 0;
        cycle();
        edge_n = 1;
        start = restart;
        if (restart) begin
            cfg_limit = 9'(lim + 7);
            cfg_key = ~key;
        end
        while (!done && edge_n < 2000) begin
            hold = (edge_n + 1 >= hold_at) && (edge_n + 1 < hold_at + hold_n);
            cycle();
            edge_n++;
        end
        hold = 0;
        chk({name, "_done_edge"}, 32'(edge_n), 32'(exp_edge));
        chk({name, "_match"}, 32'(match), 32'(exp_match));
        cycle();
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        start = 0;
        cycle();
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic       st, cl, hd;
        logic [8:0] lim;
        logic [3:0] key, prb;
        logic       e_busy;
        logic [8:0] e_cnt;
        logic       e_done, e_match, e_ab;
    } vec_t;

    vec_t tbl[14];

    initial begin
        model_reset();
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;

        tbl[0]  = '{1, 0, 0, 9'd0, 4'hC, 4'h3, 1, 9'd0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 9'd0, 4'hC, 4'h3, 1, 9'd0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 9'd0, 4'hC, 4'h3, 1, 9'd0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 9'd0, 4'hC, 4'h3, 1, 9'd0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 9'd0, 4'hC, 4'h3, 0, 9'd0, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 9'd2, 4'h5, 4'h5, 0, 9'd0, 0, 0, 0};
        tbl[6]  = '{1, 0, 0, 9'd2, 4'h5, 4'h5, 1, 9'd0, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 9'd2, 4'h5, 4'h5, 1, 9'd0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 9'd2, 4'h5, 4'h5, 1, 9'd1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 9'd2, 4'h5, 4'h5, 1, 9'd2, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 9'd2, 4'h5, 4'h5, 1, 9'd2, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 9'd2, 4'h5, 4'h5, 1, 9'd2, 1, 1, 0};
        tbl[12] = '{0, 1, 0, 9'd2, 4'h5, 4'h5, 0, 9'd2, 0, 1, 0};
        tbl[13] = '{0, 0, 0, 9'd2, 4'h5, 4'h5, 0, 9'd2, 0, 1, 0};

        for (int i = 0; i < 14; i++) begin
            start = tbl[i].st; clr = tbl[i].cl; hold = tbl[i].hd;
            cfg_limit = tbl[i].lim; cfg_key = tbl[i].key; probe = tbl[i].prb;
            cycle();
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("vec%0d_match", i), 32'(match), 32'(tbl[i].e_match));
            chk($sformatf("vec%0d_aborted", i), 32'(aborted), 32'(tbl[i].e_ab));
        end
        start = 0; clr = 0; hold = 0;

        run(5, 4'hA, 4'hA, 0, 0, 0, 9, 1, "lim5");
        run(0, 4'hC, 4'h3, 0, 0, 0, 4, 0, "lim0");
        run(3, 4'h7, 4'h7, 4, 2, 0, 9, 1, "hold2");
        run(4, 4'h2, 4'h2, 0, 0, 1, 8, 1, "busy_start");

        // clr with hold at count 2
        start = 1; cfg_limit = 9'd10; cfg_key = 4'h9; probe = 4'h9;
        cycle();
        start = 0;
        for (int i = 0; i < 20 && count != 9'd2; i++) cycle();
        chk("clr_pre_count", 32'(count), 32'd2);
        clr = 1; hold = 1; start = 1;
        cycle();
        chk("clr_aborted", 32'(aborted), 32'd1);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        clr = 0; hold = 0; start = 0;
        cycle();
        chk("clr_aborted_once", 32'(aborted), 32'd0);

        // asynchronous reset mid-count
        start = 1; cfg_limit = 9'd300;
        cycle();
        start = 0;
        for (int i = 0; i < 400 && count != 9'd100; i++) cycle();
        chk("arst_pre_count", 32'(count), 32'd100);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_match", 32'(match), 32'd0);
        chk("arst_aborted", 32'(aborted), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        run(2, 4'h1, 4'h1, 0, 0, 0, 6, 1, "post_rst");

        run(511, 4'hF, 4'hE, 0, 0, 0, 515, 0, "lim511");

        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 15) == 0);
            hold = ($urandom_range(0, 2) == 0);
            cfg_limit = 9'($urandom_range(0, 12));
            cfg_key = 4'($urandom_range(0, 3));
            probe = 4'($urandom_range(0, 3));
            cycle();
            if (done && aborted) chk("done_abort_excl", 32'd1, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
